// File: rtl/tetris_pkg.sv
// ============================================================================
// Module      : tetris_pkg
// Description : Shared types and constants for the Tetris playfield engine:
//               FSM state encoding, shape offset table and colour codes.
//               Optional feature macro: TETRIS_LINE_CLEAR_EN (adds CLEAR).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tetris_pkg;

`ifdef TETRIS_LINE_CLEAR_EN
    typedef enum logic [1:0] {
        ST_SPAWN = 2'd0,
        ST_FALL  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_OVER  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_SPAWN = 2'd0,
        ST_FALL  = 2'd1,
        ST_OVER  = 2'd3
    } state_t;
`endif

    localparam int NUM_SHAPES = 7;

    // One nibble per cell, cell k in bits [4k+3:4k]: {row[1:0], col[1:0]}.
    localparam logic [15:0] SHAPE_TBL [NUM_SHAPES] = '{
        16'h3210,   // I : (0,0) (0,1) (0,2) (0,3)
        16'h6540,   // J : (0,0) (1,0) (1,1) (1,2)
        16'h6542,   // L : (0,2) (1,0) (1,1) (1,2)
        16'h6521,   // O : (0,1) (0,2) (1,1) (1,2)
        16'h5421,   // S : (0,1) (0,2) (1,0) (1,1)
        16'h6541,   // T : (0,1) (1,0) (1,1) (1,2)
        16'h6510    // Z : (0,0) (0,1) (1,1) (1,2)
    };

    localparam logic [2:0] EMPTY   = 3'd0;
    localparam logic [2:0] COLOR_I = 3'd1;
    localparam logic [2:0] COLOR_J = 3'd2;
    localparam logic [2:0] COLOR_L = 3'd3;
    localparam logic [2:0] COLOR_O = 3'd4;
    localparam logic [2:0] COLOR_S = 3'd5;
    localparam logic [2:0] COLOR_T = 3'd6;
    localparam logic [2:0] COLOR_Z = 3'd7;

    localparam logic [2:0] SHAPE_COLOR [NUM_SHAPES] = '{
        COLOR_I, COLOR_J, COLOR_L, COLOR_O, COLOR_S, COLOR_T, COLOR_Z
    };

    // The LFSR can deliver 7, which has no shape; fold it onto I.
    function automatic logic [2:0] piece_index(input logic [2:0] sel);
        return (sel == 3'd7) ? 3'd0 : sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tetris_field_if.sv
// ============================================================================
// Module      : tetris_field_if
// Description : Cell-read bus between the playfield and the pixel generator.
//               master = pixel generator, slave = playfield.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tetris_field_if #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int CW   = 3
);
    localparam int CLW = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);

    logic [CLW-1:0] rd_col;
    logic [RW-1:0]  rd_row;
    logic [CW-1:0]  rd_color;

    modport master (output rd_col, output rd_row, input  rd_color);
    modport slave  (input  rd_col, input  rd_row, output rd_color);
endinterface

`default_nettype wire

// File: rtl/tetris_shape_rom.sv
// ============================================================================
// Module      : tetris_shape_rom
// Description : Combinational shape lookup: piece index + anchor in, four
//               absolute cell coordinates and the piece colour out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tetris_shape_rom
    import tetris_pkg::*;
#(
    parameter int RW  = 5,
    parameter int CLW = 4,
    parameter int CW  = 3
) (
    input  logic [2:0]          piece,
    input  logic [RW-1:0]       anchor_row,
    input  logic [CLW-1:0]      anchor_col,
    output logic [3:0][RW-1:0]  cell_row,
    output logic [3:0][CLW-1:0] cell_col,
    output logic [CW-1:0]       color
);

    logic [2:0]  idx;
    logic [15:0] offs;

    assign idx   = piece_index(piece);
    assign offs  = SHAPE_TBL[idx];
    assign color = CW'(SHAPE_COLOR[idx]);

    generate
        for (genvar k = 0; k < 4; k++) begin : g_cell
            assign cell_row[k] = anchor_row + RW'(offs[4*k+2 +: 2]);
            assign cell_col[k] = anchor_col + CLW'(offs[4*k +: 2]);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/tetris_field.sv
// ============================================================================
// Module      : tetris_field
// Description : Tetris playfield engine. Locked-cell grid plus one falling
//               piece; one action per clk_1hz tick (spawn / fall / lock /
//               line clear). Combinational cell-read port for the VGA side.
//               Optional feature macro: TETRIS_LINE_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tetris_field
    import tetris_pkg::*;
#(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int CW   = 3
) (
    input  logic          clk_1hz,
    input  logic          rst,
    input  logic [2:0]    piece_sel,
    tetris_field_if.slave rd,
    output logic          piece_active,
    output logic          game_over,
    output logic [15:0]   lines
);

    localparam int RW  = $clog2(ROWS);
    localparam int CLW = $clog2(COLS);
    localparam logic [CLW-1:0] SC         = CLW'(COLS / 2 - 2);
    localparam logic [CW-1:0]  EMPTY_CELL = CW'(EMPTY);

    state_t        state;
    logic [CW-1:0] grid [ROWS][COLS];
    logic [2:0]    cur_piece;
    logic [RW-1:0] cur_row;

    logic [2:0]          rom_piece;
    logic [RW-1:0]       rom_row;
    logic [3:0][RW-1:0]  cell_row;
    logic [3:0][CLW-1:0] cell_col;
    logic [CW-1:0]       cell_color;
    logic                overlap;
    logic                blocked;
    logic [CW-1:0]       color_out;

    // No piece is active while in SPAWN, so the one ROM can serve both the
    // spawn candidate and the falling piece.
    assign rom_piece = (state == ST_SPAWN) ? piece_sel : cur_piece;
    assign rom_row   = (state == ST_SPAWN) ? '0 : cur_row;

    tetris_shape_rom #(
        .RW  (RW),
        .CLW (CLW),
        .CW  (CW)
    ) u_shape_rom (
        .piece      (rom_piece),
        .anchor_row (rom_row),
        .anchor_col (SC),
        .cell_row   (cell_row),
        .cell_col   (cell_col),
        .color      (cell_color)
    );

    // Collision checks: overlap at current position, and blocked one row down.
    always_comb begin
        overlap = 1'b0;
        blocked = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (grid[cell_row[k]][cell_col[k]] != EMPTY_CELL)
                overlap = 1'b1;
            if (({1'b0, cell_row[k]} + (RW+1)'(1)) >= (RW+1)'(ROWS))
                blocked = 1'b1;
            else if (grid[cell_row[k] + RW'(1)][cell_col[k]] != EMPTY_CELL)
                blocked = 1'b1;
        end
    end

`ifdef TETRIS_LINE_CLEAR_EN
    logic [ROWS-1:0] row_full;
    logic            full_any;
    logic [RW-1:0]   full_row;

    // A row is full when none of its cells is empty.
    always_comb begin
        row_full = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (grid[r][c] == EMPTY_CELL)
                    row_full[r] = 1'b0;
    end

    // Pick the lowest (highest-index) full row.
    always_comb begin
        full_any = |row_full;
        full_row = '0;
        for (int r = 0; r < ROWS; r++)
            if (row_full[r])
                full_row = RW'(r);
    end

    // Cleared-line counter, saturating.
    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst)
            lines <= '0;
        else if (state == ST_CLEAR && full_any && lines != 16'hFFFF)
            lines <= lines + 16'd1;
    end
`else
    assign lines = '0;
`endif

    // Playfield FSM: one spawn / fall / lock / clear action per tick.
    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            state        <= ST_SPAWN;
            piece_active <= 1'b0;
            game_over    <= 1'b0;
            cur_piece    <= '0;
            cur_row      <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    grid[r][c] <= EMPTY_CELL;
        end else begin
            case (state)
                ST_SPAWN: begin
                    if (overlap) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end else begin
                        cur_piece    <= piece_sel;
                        cur_row      <= '0;
                        piece_active <= 1'b1;
                        state        <= ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (!blocked) begin
                        cur_row <= cur_row + RW'(1);
                    end else begin
                        for (int k = 0; k < 4; k++)
                            grid[cell_row[k]][cell_col[k]] <= cell_color;
                        piece_active <= 1'b0;
`ifdef TETRIS_LINE_CLEAR_EN
                        state <= ST_CLEAR;
`else
                        state <= ST_SPAWN;
`endif
                    end
                end
`ifdef TETRIS_LINE_CLEAR_EN
                ST_CLEAR: begin
                    if (full_any) begin
                        for (int c = 0; c < COLS; c++)
                            grid[0][c] <= EMPTY_CELL;
                        for (int r = 1; r < ROWS; r++)
                            if (RW'(r) <= full_row)
                                for (int c = 0; c < COLS; c++)
                                    grid[r][c] <= grid[r-1][c];
                    end else begin
                        state <= ST_SPAWN;
                    end
                end
`endif
                ST_OVER: state <= ST_OVER;
                default: state <= ST_SPAWN;
            endcase
        end
    end

    // Read port: out-of-range reads 0, active piece overrides the grid.
    always_comb begin
        color_out = EMPTY_CELL;
        if (({1'b0, rd.rd_col} < (CLW+1)'(COLS)) &&
            ({1'b0, rd.rd_row} < (RW+1)'(ROWS))) begin
            color_out = grid[rd.rd_row][rd.rd_col];
            for (int k = 0; k < 4; k++)
                if (piece_active && cell_row[k] == rd.rd_row &&
                    cell_col[k] == rd.rd_col)
                    color_out = cell_color;
        end
    end

    assign rd.rd_color = color_out;

endmodule

`default_nettype wire

// File: tb/tb_tetris_field.sv
// ============================================================================
// Module      : tb_tetris_field
// Description : Self-checking bench for tetris_field. Three instances
//               (10x20, 4x4, 10x4); expectations follow TETRIS_LINE_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tetris_field;

    logic clk_1hz = 1'b0;
    always #10 clk_1hz = ~clk_1hz;

    logic        rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic [2:0]  sel0 = 3'd3, sel1 = 3'd0, sel2 = 3'd3;
    logic        act0, act1, act2;
    logic        over0, over1, over2;
    logic [15:0] lines0, lines1, lines2;

    tetris_field_if #(.COLS(10), .ROWS(20), .CW(3)) bus0();
    tetris_field_if #(.COLS(4),  .ROWS(4),  .CW(3)) bus1();
    tetris_field_if #(.COLS(10), .ROWS(4),  .CW(3)) bus2();

    tetris_field #(.COLS(10), .ROWS(20), .CW(3)) dut0 (
        .clk_1hz(clk_1hz), .rst(rst0), .piece_sel(sel0), .rd(bus0),
        .piece_active(act0), .game_over(over0), .lines(lines0));
    tetris_field #(.COLS(4), .ROWS(4), .CW(3)) dut1 (
        .clk_1hz(clk_1hz), .rst(rst1), .piece_sel(sel1), .rd(bus1),
        .piece_active(act1), .game_over(over1), .lines(lines1));
    tetris_field #(.COLS(10), .ROWS(4), .CW(3)) dut2 (
        .clk_1hz(clk_1hz), .rst(rst2), .piece_sel(sel2), .rd(bus2),
        .piece_active(act2), .game_over(over2), .lines(lines2));

    typedef struct {
        int    dut;
        int    tick;
        int    col;
        int    row;
        int    color;
        int    active;
        int    over;
        int    lines;
        string name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   applied  = 0;

    task automatic add(input int d, input int t, input int c, input int r,
                       input int col, input int a, input int o, input int l,
                       input string n);
        vec_t v;
        v.dut = d; v.tick = t; v.col = c; v.row = r; v.color = col;
        v.active = a; v.over = o; v.lines = l; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", n, act, exp);
        end
    endtask

    task automatic set_rd(input int d, input int c, input int r);
        case (d)
            0: begin bus0.rd_col = 4'(c); bus0.rd_row = 5'(r); end
            1: begin bus1.rd_col = 2'(c); bus1.rd_row = 2'(r); end
            default: begin bus2.rd_col = 4'(c); bus2.rd_row = 2'(r); end
        endcase
    endtask

    task automatic set_rst(input int d, input logic v);
        case (d)
            0: rst0 = v;
            1: rst1 = v;
            default: rst2 = v;
        endcase
    endtask

    task automatic set_sel(input int d, input int s);
        case (d)
            0: sel0 = 3'(s);
            1: sel1 = 3'(s);
            default: sel2 = 3'(s);
        endcase
    endtask

    task automatic sample(input int d, output int color, output int a,
                          output int o, output int l);
        case (d)
            0: begin color = int'(bus0.rd_color); a = int'(act0); o = int'(over0); l = int'(lines0); end
            1: begin color = int'(bus1.rd_color); a = int'(act1); o = int'(over1); l = int'(lines1); end
            default: begin color = int'(bus2.rd_color); a = int'(act2); o = int'(over2); l = int'(lines2); end
        endcase
    endtask

    task automatic compare_one();
        vec_t e;
        int   c, a, o, l;
        e = sb.pop_front();
        sample(e.dut, c, a, o, l);
        check($sformatf("%s t%0d (c%0d,r%0d) color", e.name, e.tick, e.col, e.row), c, e.color);
        check($sformatf("%s t%0d active", e.name, e.tick), a, e.active);
        check($sformatf("%s t%0d game_over", e.name, e.tick), o, e.over);
        check($sformatf("%s t%0d lines", e.name, e.tick), l, e.lines);
    endtask

    task automatic apply_tick(input int d, input int t);
        foreach (vecs[i]) begin
            if (vecs[i].dut == d && vecs[i].tick == t) begin
                set_rd(d, vecs[i].col, vecs[i].row);
                sb.push_back(vecs[i]);
                applied++;
                #1;
                compare_one();
            end
        end
    endtask

    task automatic run(input int d, input int nticks, input int sel_first,
                       input int sel_rest);
        set_sel(d, sel_first);
        set_rst(d, 1'b1);
        @(negedge clk_1hz);
        set_rst(d, 1'b0);
        #1;
        apply_tick(d, 0);
        for (int t = 1; t <= nticks; t++) begin
            @(posedge clk_1hz);
            #2;
            if (t == 1) set_sel(d, sel_rest);
            apply_tick(d, t);
        end
    endtask

    task automatic fill_table();
        // 10x20, O piece held: anchor column 3, cells at columns 4..5.
        add(0, 0, 4, 0, 0, 0, 0, 0, "A reset");
        add(0, 1, 4, 0, 4, 1, 0, 0, "A spawn");
        add(0, 1, 5, 0, 4, 1, 0, 0, "A spawn");
        add(0, 1, 4, 1, 4, 1, 0, 0, "A spawn");
        add(0, 1, 5, 1, 4, 1, 0, 0, "A spawn");
        add(0, 1, 3, 0, 0, 1, 0, 0, "A spawn edge");
        add(0, 1, 6, 1, 0, 1, 0, 0, "A spawn edge");
        add(0, 2, 4, 0, 0, 1, 0, 0, "A fall");
        add(0, 2, 4, 2, 4, 1, 0, 0, "A fall");
        add(0, 19, 4, 18, 4, 1, 0, 0, "A bottom");
        add(0, 19, 5, 19, 4, 1, 0, 0, "A bottom");
        add(0, 19, 4, 17, 0, 1, 0, 0, "A bottom");
        add(0, 20, 4, 19, 4, 0, 0, 0, "A lock");
        add(0, 20, 5, 18, 4, 0, 0, 0, "A lock");
        add(0, 20, 10, 19, 0, 0, 0, 0, "A col oob");
        add(0, 20, 4, 25, 0, 0, 0, 0, "A row oob");
`ifdef TETRIS_LINE_CLEAR_EN
        add(0, 21, 4, 0, 0, 0, 0, 0, "A clear");
        add(0, 21, 4, 19, 4, 0, 0, 0, "A clear");
        add(0, 22, 4, 0, 4, 1, 0, 0, "A respawn");
        add(0, 22, 5, 1, 4, 1, 0, 0, "A respawn");
        add(0, 22, 4, 19, 4, 1, 0, 0, "A respawn");
`else
        add(0, 21, 4, 0, 4, 1, 0, 0, "A respawn");
        add(0, 21, 4, 19, 4, 1, 0, 0, "A respawn");
        add(0, 22, 4, 0, 0, 1, 0, 0, "A refall");
        add(0, 22, 4, 2, 4, 1, 0, 0, "A refall");
        add(0, 22, 5, 18, 4, 1, 0, 0, "A refall");
`endif
        // 4x4, first piece sel=0 (I), later pieces sel=7 (also I).
        add(1, 0, 0, 0, 0, 0, 0, 0, "B reset");
        add(1, 1, 0, 0, 1, 1, 0, 0, "B spawn");
        add(1, 1, 3, 0, 1, 1, 0, 0, "B spawn");
        add(1, 1, 0, 1, 0, 1, 0, 0, "B spawn");
        add(1, 4, 0, 3, 1, 1, 0, 0, "B bottom");
        add(1, 4, 3, 3, 1, 1, 0, 0, "B bottom");
        add(1, 4, 0, 2, 0, 1, 0, 0, "B bottom");
        add(1, 5, 0, 3, 1, 0, 0, 0, "B lock");
        add(1, 5, 2, 3, 1, 0, 0, 0, "B lock");
`ifdef TETRIS_LINE_CLEAR_EN
        add(1, 6, 0, 3, 0, 0, 0, 1, "B clear");
        add(1, 6, 3, 3, 0, 0, 0, 1, "B clear");
        add(1, 7, 0, 0, 0, 0, 0, 1, "B idle");
        add(1, 8, 0, 0, 1, 1, 0, 1, "B sel7 spawn");
        add(1, 8, 3, 0, 1, 1, 0, 1, "B sel7 spawn");
        add(1, 8, 0, 3, 0, 1, 0, 1, "B sel7 spawn");
`else
        add(1, 6, 0, 0, 1, 1, 0, 0, "B sel7 spawn");
        add(1, 6, 0, 3, 1, 1, 0, 0, "B full kept");
        add(1, 7, 2, 1, 1, 1, 0, 0, "B fall");
        add(1, 7, 1, 0, 0, 1, 0, 0, "B fall");
        add(1, 7, 3, 3, 1, 1, 0, 0, "B full kept");
        add(1, 8, 0, 2, 1, 1, 0, 0, "B fall");
        add(1, 8, 0, 3, 1, 1, 0, 0, "B full kept");
`endif
        // 10x4, O held: stacks two Os then overflows.
        add(2, 3, 4, 2, 4, 1, 0, 0, "C bottom");
        add(2, 3, 5, 3, 4, 1, 0, 0, "C bottom");
        add(2, 4, 4, 3, 4, 0, 0, 0, "C lock1");
`ifdef TETRIS_LINE_CLEAR_EN
        add(2, 6, 4, 0, 4, 1, 0, 0, "C spawn2");
        add(2, 6, 5, 1, 4, 1, 0, 0, "C spawn2");
        add(2, 7, 4, 1, 4, 0, 0, 0, "C lock2");
        add(2, 8, 4, 0, 4, 0, 0, 0, "C clear idle");
        add(2, 9, 4, 0, 4, 0, 1, 0, "C over");
        add(2, 9, 5, 2, 4, 0, 1, 0, "C over");
`else
        add(2, 5, 4, 0, 4, 1, 0, 0, "C spawn2");
        add(2, 6, 4, 1, 4, 0, 0, 0, "C lock2");
        add(2, 7, 4, 0, 4, 0, 1, 0, "C over");
`endif
        add(2, 12, 5, 0, 4, 0, 1, 0, "C frozen");
        add(2, 12, 4, 3, 4, 0, 1, 0, "C frozen");
        add(2, 12, 3, 0, 0, 0, 1, 0, "C frozen");
    endtask

    initial begin
        int c, a, o, l;
        set_rd(0, 0, 0);
        set_rd(1, 0, 0);
        set_rd(2, 0, 0);
        fill_table();

        // Reset state: every in-range cell of the 10x20 field reads empty.
        #3;
        for (int r = 0; r < 20; r++) begin
            for (int cc = 0; cc < 10; cc++) begin
                set_rd(0, cc, r);
                #1;
                sample(0, c, a, o, l);
                check($sformatf("reset cell (c%0d,r%0d)", cc, r), c, 0);
            end
        end
        check("reset lines", int'(lines0), 0);
        check("reset active", int'(act0), 0);
        check("reset game_over", int'(over0), 0);

        run(0, 22, 3, 3);
        run(1, 8, 0, 7);
        run(2, 12, 3, 3);

        // Async reset mid-fall: piece disappears with no tick.
        set_sel(0, 3);
        set_rst(0, 1'b1);
        @(negedge clk_1hz);
        set_rst(0, 1'b0);
        repeat (5) @(posedge clk_1hz);
        #2;
        set_rd(0, 4, 4);
        #1;
        sample(0, c, a, o, l);
        check("midfall before rst color", c, 4);
        check("midfall before rst active", a, 1);
        set_rst(0, 1'b1);
        #1;
        sample(0, c, a, o, l);
        check("midfall after rst color", c, 0);
        check("midfall after rst active", a, 0);

        // Async reset right after a lock that filled a row.
        set_sel(1, 0);
        set_rst(1, 1'b1);
        @(negedge clk_1hz);
        set_rst(1, 1'b0);
        repeat (5) @(posedge clk_1hz);
        #2;
        set_rd(1, 0, 3);
        #1;
        sample(1, c, a, o, l);
        check("midclear before rst color", c, 1);
        set_rst(1, 1'b1);
        #1;
        sample(1, c, a, o, l);
        check("midclear after rst color", c, 0);
        check("midclear after rst lines", l, 0);

        // Async reset releases game over and wipes the frozen grid.
        #1;
        set_rd(2, 4, 3);
        set_rst(2, 1'b1);
        #1;
        sample(2, c, a, o, l);
        check("over rst game_over", o, 0);
        check("over rst color", c, 0);

        check("vectors applied", applied, vecs.size());
        check("scoreboard drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
